uart_access_arbiter: RTL and testbench
======================================

UART_ACCESS_ARBITER -- requirements
Module: uart_access_arbiter

Interface
REQ-001 SHALL have parameter REQ_DEPTH, default 4, meaning request queue depth (power of two, 2..16).
REQ-002 SHALL have parameter ID_WIDTH, default 8, meaning access-ID width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk_i, input, 1 bit: system clock.
REQ-005 SHALL have port arst_ni, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port req_id_i, input, ID_WIDTH bits: requesting access ID.
REQ-007 SHALL have port req_valid_i, input, 1 bit: request valid.
REQ-008 SHALL have port req_ready_o, output, 1 bit: queue can accept a request.
REQ-009 SHALL have port gnt_id_o, output, ID_WIDTH bits: granted ID.
REQ-010 SHALL have port gnt_valid_o, output, 1 bit: grant available.
REQ-011 SHALL have port gnt_ready_i, input, 1 bit: grant consumed.
REQ-012 SHALL have port release_i, input, 1 bit: release strobe.
REQ-013 SHALL have port release_id_i, input, ID_WIDTH bits: releasing ID.
REQ-014 SHALL have port activity_i, input, 1 bit: owner bus access pulse.
REQ-015 SHALL have port tx_busy_i, input, 1 bit: UART TX FIFO non-empty or shifting.
REQ-016 SHALL have port timeout_cycles_i, input, 16 bits: idle-ownership limit; 0 disables the limit.
REQ-017 SHALL have port owner_id_o, output, ID_WIDTH bits: current owner.
REQ-018 SHALL have port owner_valid_o, output, 1 bit: owner held.
REQ-019 SHALL have port timeout_o, output, 1 bit: one-cycle pulse on forced release.
REQ-020 SHALL have port rel_err_o, output, 1 bit: one-cycle pulse on an ignored release.

Function
REQ-021 SHALL implement request queueing as a FIFO of REQ_DEPTH entries, with req_ready_o = (count < REQ_DEPTH), computed from registered count only.
REQ-022 SHALL push a request when req_valid_i && req_ready_o; when the queue is full, a same-cycle pop SHALL NOT raise req_ready_o in that cycle.
REQ-023 SHALL implement an FSM with states IDLE, GRANT, OWNED and DRAIN.
REQ-024 In IDLE with the queue non-empty, the FSM SHALL pop the head into the owner register and move to GRANT on the next cycle; a push into an empty queue in cycle N SHALL give gnt_valid_o=1 in cycle N+2.
REQ-025 In GRANT, the block SHALL drive gnt_valid_o=1 and gnt_id_o=owner; on gnt_ready_i it SHALL move to OWNED and clear the idle counter.
REQ-026 owner_valid_o SHALL be 1 in GRANT and OWNED and 0 otherwise; owner_id_o SHALL hold its last value outside those states.
REQ-027 In OWNED, a 16-bit idle counter SHALL increment each cycle without activity_i, clear on activity_i, and saturate at 0xFFFF.
REQ-028 In OWNED with timeout_cycles_i != 0 and counter+1 == timeout_cycles_i without activity_i, the FSM SHALL pulse timeout_o and move to DRAIN.
REQ-029 In GRANT or OWNED, release_i with release_id_i == owner SHALL move the FSM to DRAIN; a matching release SHALL take priority over timeout in the same cycle.
REQ-030 release_i with a mismatched ID, or in IDLE/DRAIN, SHALL pulse rel_err_o and change no state.
REQ-031 In DRAIN, the FSM SHALL stay while tx_busy_i=1 and move to IDLE in the first cycle tx_busy_i=0; the minimum DRAIN residency SHALL be 1 cycle.
REQ-032 Grants SHALL be strictly FIFO order; duplicate IDs SHALL be queued as separate requests.
REQ-033 Queue pointers SHALL wrap modulo REQ_DEPTH; count SHALL be log2(REQ_DEPTH)+1 bits wide.

Reset
REQ-034 On reset, the block SHALL go to IDLE, empty the queue, zero the counter, and drive owner_id_o=0, owner_valid_o=0, gnt_valid_o=0, timeout_o=0, rel_err_o=0 and req_ready_o=1.
REQ-035 Reset asserted mid-ownership SHALL take effect asynchronously and drop all queued requests; no grant SHALL be issued until a new request arrives after reset release.

Verification
REQ-036 Bench SHALL cover: push ID 0x05 at cycle 10 in IDLE -> gnt_valid_o=1 with gnt_id_o=0x05 at cycle 12; gnt_ready_i at 13 -> owner_valid_o=1 and owner_id_o=0x05.
REQ-037 Bench SHALL cover: push 0x01, 0x02, 0x03, 0x04, then 0x09 -> req_ready_o=0 after the 4th push and 0x09 stalls; grants SHALL follow the order 1, 2, 3, 4.
REQ-038 Bench SHALL cover: owner 0x05, timeout_cycles_i=8, no activity -> timeout_o pulse 8 cycles after OWNED entry, then DRAIN.
REQ-039 Bench SHALL cover: owner 0x05, release with ID 0x06 -> rel_err_o pulse and owner unchanged; release with ID 0x05 while tx_busy_i=1 for 20 cycles -> IDLE in the cycle tx_busy_i falls.
REQ-040 Bench SHALL cover: matching release and timeout in the same cycle -> DRAIN with no timeout_o pulse.
REQ-041 Bench SHALL cover: reset during OWNED with 3 queued requests -> all outputs at reset values and no grant after release of reset.

Source files
------------

// File: rtl/uart_access_arbiter.sv
// Single-owner access arbiter for a shared UART: FIFO-ordered requests, grant
// handshake, idle-ownership timeout and a drain phase that waits for TX to empty.
module uart_access_arbiter #(
   parameter int REQ_DEPTH = 4,
   parameter int ID_WIDTH  = 8
) (
   input  logic                clk_i,
   input  logic                arst_ni,
   input  logic [ID_WIDTH-1:0] req_id_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   output logic [ID_WIDTH-1:0] gnt_id_o,
   output logic                gnt_valid_o,
   input  logic                gnt_ready_i,
   input  logic                release_i,
   input  logic [ID_WIDTH-1:0] release_id_i,
   input  logic                activity_i,
   input  logic                tx_busy_i,
   input  logic [15:0]         timeout_cycles_i,
   output logic [ID_WIDTH-1:0] owner_id_o,
   output logic                owner_valid_o,
   output logic                timeout_o,
   output logic                rel_err_o
);

   localparam int PTR_W = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANT,
      ST_OWNED,
      ST_DRAIN
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [ID_WIDTH-1:0] r_mem [REQ_DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [CNT_W-1:0]    r_count;
   logic [ID_WIDTH-1:0] r_owner;
   logic [15:0]         r_idle_cnt;
   logic [15:0]         w_idle_cnt_next;
   logic                r_timeout;
   logic                r_rel_err;

   logic w_push;
   logic w_pop;
   logic w_holding;
   logic w_rel_match;
   logic w_rel_err;
   logic w_timeout_hit;
   logic w_timeout;

   // Ready comes from the registered count only, so a pop never frees a slot
   // for a push in the same cycle.
   assign req_ready_o   = (r_count < CNT_W'(REQ_DEPTH));
   assign w_push        = req_valid_i && req_ready_o;
   assign w_pop         = (r_state == ST_IDLE) && (r_count != '0);
   assign w_holding     = (r_state == ST_GRANT) || (r_state == ST_OWNED);
   assign w_rel_match   = release_i && w_holding && (release_id_i == r_owner);
   assign w_rel_err     = release_i && !w_rel_match;
   assign w_timeout_hit = (r_state == ST_OWNED) && !activity_i &&
                          (timeout_cycles_i != 16'd0) &&
                          (({1'b0, r_idle_cnt} + 17'd1) == {1'b0, timeout_cycles_i});
   assign w_timeout     = w_timeout_hit && !w_rel_match;

   always_comb begin
      w_state_next    = r_state;
      w_idle_cnt_next = r_idle_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_pop) begin
               w_state_next = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (w_rel_match) begin
               w_state_next = ST_DRAIN;
            end else if (gnt_ready_i) begin
               w_state_next    = ST_OWNED;
               w_idle_cnt_next = 16'd0;
            end
         end
         ST_OWNED: begin
            // A matching release outranks a timeout landing in the same cycle.
            if (w_rel_match || w_timeout) begin
               w_state_next = ST_DRAIN;
            end else if (activity_i) begin
               w_idle_cnt_next = 16'd0;
            end else if (r_idle_cnt != 16'hFFFF) begin
               w_idle_cnt_next = r_idle_cnt + 16'd1;
            end
         end
         ST_DRAIN: begin
            if (!tx_busy_i) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         r_state    <= ST_IDLE;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_owner    <= '0;
         r_idle_cnt <= 16'd0;
         r_timeout  <= 1'b0;
         r_rel_err  <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_idle_cnt <= w_idle_cnt_next;
         r_timeout  <= w_timeout;
         r_rel_err  <= w_rel_err;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_owner  <= r_mem[r_rd_ptr];
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Queue storage carries no reset; emptiness is tracked by the pointers/count.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= req_id_i;
      end
   end

   assign gnt_valid_o   = (r_state == ST_GRANT);
   assign gnt_id_o      = r_owner;
   assign owner_valid_o = w_holding;
   assign owner_id_o    = r_owner;
   assign timeout_o     = r_timeout;
   assign rel_err_o     = r_rel_err;

endmodule

// File: tb/tb_uart_access_arbiter.sv
// Directed bench for uart_access_arbiter: queue-based reference model checked
// every cycle, plus hand-computed expectations on the key scenarios.
module tb_uart_access_arbiter;

   localparam int DEPTH = 4;
   localparam int IDW   = 8;

   logic            clk_i       = 1'b0;
   logic            arst_ni     = 1'b0;
   logic [IDW-1:0]  req_id_i    = '0;
   logic            req_valid_i = 1'b0;
   logic            req_ready_o;
   logic [IDW-1:0]  gnt_id_o;
   logic            gnt_valid_o;
   logic            gnt_ready_i = 1'b0;
   logic            release_i   = 1'b0;
   logic [IDW-1:0]  release_id_i = '0;
   logic            activity_i  = 1'b0;
   logic            tx_busy_i   = 1'b0;
   logic [15:0]     timeout_cycles_i = 16'd0;
   logic [IDW-1:0]  owner_id_o;
   logic            owner_valid_o;
   logic            timeout_o;
   logic            rel_err_o;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;

   uart_access_arbiter #(.REQ_DEPTH(DEPTH), .ID_WIDTH(IDW)) dut (
      .clk_i            (clk_i),
      .arst_ni          (arst_ni),
      .req_id_i         (req_id_i),
      .req_valid_i      (req_valid_i),
      .req_ready_o      (req_ready_o),
      .gnt_id_o         (gnt_id_o),
      .gnt_valid_o      (gnt_valid_o),
      .gnt_ready_i      (gnt_ready_i),
      .release_i        (release_i),
      .release_id_i     (release_id_i),
      .activity_i       (activity_i),
      .tx_busy_i        (tx_busy_i),
      .timeout_cycles_i (timeout_cycles_i),
      .owner_id_o       (owner_id_o),
      .owner_valid_o    (owner_valid_o),
      .timeout_o        (timeout_o),
      .rel_err_o        (rel_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Reference model: phase of the single ownership slot plus a queue of IDs.
   typedef enum {M_IDLE, M_GRANT, M_OWNED, M_DRAIN} mphase_t;
   mphase_t        m_ph    = M_IDLE;
   int unsigned    m_q[$];
   int unsigned    m_owner = 0;
   int unsigned    m_idle  = 0;
   bit             m_tmo   = 0;
   bit             m_rerr  = 0;
   bit             m_push;
   bit             m_match;

   initial begin
      forever begin
         @(posedge clk_i or negedge arst_ni);
         if (!arst_ni) begin
            m_q.delete();
            m_ph = M_IDLE; m_owner = 0; m_idle = 0; m_tmo = 0; m_rerr = 0;
         end else begin
            m_push  = req_valid_i && (m_q.size() < DEPTH);
            m_match = release_i && (m_ph == M_GRANT || m_ph == M_OWNED) &&
                      (release_id_i == m_owner[IDW-1:0]);
            m_tmo   = 0;
            m_rerr  = release_i && !m_match;
            case (m_ph)
               M_IDLE:  if (m_q.size() != 0) begin m_owner = m_q.pop_front(); m_ph = M_GRANT; end
               M_GRANT: if (m_match) m_ph = M_DRAIN;
                        else if (gnt_ready_i) begin m_ph = M_OWNED; m_idle = 0; end
               M_OWNED: if (m_match) m_ph = M_DRAIN;
                        else if (activity_i) m_idle = 0;
                        else if (timeout_cycles_i != 0 && m_idle + 1 == timeout_cycles_i) begin
                           m_tmo = 1; m_ph = M_DRAIN;
                        end else if (m_idle < 65535) m_idle = m_idle + 1;
               M_DRAIN: if (!tx_busy_i) m_ph = M_IDLE;
               default: m_ph = M_IDLE;
            endcase
            if (m_push) m_q.push_back(req_id_i);
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk_i);
         #1;
         if (arst_ni) begin
            chk("m_req_ready",   req_ready_o,   m_q.size() < DEPTH);
            chk("m_gnt_valid",   gnt_valid_o,   m_ph == M_GRANT);
            if (m_ph == M_GRANT) chk("m_gnt_id", gnt_id_o, m_owner);
            chk("m_owner_valid", owner_valid_o, m_ph == M_GRANT || m_ph == M_OWNED);
            chk("m_owner_id",    owner_id_o,    m_owner);
            chk("m_timeout",     timeout_o,     m_tmo);
            chk("m_rel_err",     rel_err_o,     m_rerr);
         end
      end
   end

   task automatic tick();
      @(negedge clk_i);
      cyc++;
   endtask

   task automatic wait_gnt(input logic [IDW-1:0] exp_id);
      int n = 0;
      while (!gnt_valid_o && n < 30) begin tick(); n++; end
      chk("gnt_arrives", gnt_valid_o, 1);
      chk("gnt_order_id", gnt_id_o, exp_id);
      $display("grant id=%02h at cycle %0d", gnt_id_o, cyc);
   endtask

   task automatic grant_owner(input logic [IDW-1:0] id);
      req_valid_i = 1'b1; req_id_i = id;
      tick();
      req_valid_i = 1'b0;
      wait_gnt(id);
      gnt_ready_i = 1'b1;
      tick();
      gnt_ready_i = 1'b0;
   endtask

   task automatic release_owner(input logic [IDW-1:0] id);
      release_i = 1'b1; release_id_i = id;
      tick();
      release_i = 1'b0;
   endtask

   initial begin
      int r;
      int e;
      logic [IDW-1:0] order [4];
      order[0] = 8'h02; order[1] = 8'h03; order[2] = 8'h04; order[3] = 8'h09;

      // Reset values
      timeout_cycles_i = 16'd8;
      repeat (3) tick();
      chk("rst_req_ready",   req_ready_o,   1);
      chk("rst_gnt_valid",   gnt_valid_o,   0);
      chk("rst_owner_valid", owner_valid_o, 0);
      chk("rst_owner_id",    owner_id_o,    0);
      chk("rst_timeout",     timeout_o,     0);
      chk("rst_rel_err",     rel_err_o,     0);
      arst_ni = 1'b1;

      // Push 0x05 at cycle 10 -> grant at 12, accept at 13
      while (cyc < 10) tick();
      req_valid_i = 1'b1; req_id_i = 8'h05;
      tick();
      req_valid_i = 1'b0;
      chk("c11_no_gnt", gnt_valid_o, 0);
      tick();
      chk("c12_gnt_valid", gnt_valid_o, 1);
      chk("c12_gnt_id",    gnt_id_o,    8'h05);
      tick();
      chk("c13_gnt_hold", gnt_valid_o, 1);
      gnt_ready_i = 1'b1;
      tick();
      gnt_ready_i = 1'b0;
      chk("c14_owner_valid", owner_valid_o, 1);
      chk("c14_owner_id",    owner_id_o,    8'h05);
      chk("c14_gnt_clear",   gnt_valid_o,   0);

      // OWNED from cycle 14, limit 8, no activity -> pulse at cycle 22 in DRAIN
      while (cyc < 22) begin
         chk("tmo_quiet", timeout_o, 0);
         tick();
      end
      chk("c22_timeout",     timeout_o,     1);
      chk("c22_owner_valid", owner_valid_o, 0);
      chk("c22_owner_hold",  owner_id_o,    8'h05);
      tick();
      chk("c23_timeout_end", timeout_o, 0);

      // Mismatched release, then matching release with TX busy for 20 cycles
      timeout_cycles_i = 16'd0;
      grant_owner(8'h05);
      release_owner(8'h06);
      chk("relerr_pulse", rel_err_o,     1);
      chk("relerr_owner", owner_valid_o, 1);
      chk("relerr_id",    owner_id_o,    8'h05);
      tick();
      chk("relerr_end",   rel_err_o,     0);
      tx_busy_i = 1'b1;
      r = cyc;
      release_owner(8'h05);
      chk("drain_owner_valid", owner_valid_o, 0);
      req_valid_i = 1'b1; req_id_i = 8'h07;
      tick();
      req_valid_i = 1'b0;
      release_owner(8'h05);
      chk("drain_relerr", rel_err_o, 1);
      while (cyc < r + 20) begin
         chk("drain_no_gnt", gnt_valid_o, 0);
         tick();
      end
      tx_busy_i = 1'b0;
      tick();
      chk("idle_pop_no_gnt", gnt_valid_o, 0);
      tick();
      chk("post_drain_gnt", gnt_valid_o, 1);
      chk("post_drain_id",  gnt_id_o,    8'h07);

      // Matching release in the same cycle the timeout would fire
      timeout_cycles_i = 16'd4;
      gnt_ready_i = 1'b1;
      tick();
      gnt_ready_i = 1'b0;
      e = cyc;
      while (cyc < e + 3) tick();
      release_owner(8'h07);
      chk("relwin_no_tmo",  timeout_o,     0);
      chk("relwin_drain",   owner_valid_o, 0);
      chk("relwin_no_err",  rel_err_o,     0);
      tick();
      chk("relwin_no_tmo2", timeout_o,     0);
      timeout_cycles_i = 16'd0;

      // Fill queue behind owner 0x0A, 0x09 stalls, grants drain in order
      grant_owner(8'h0A);
      for (int i = 1; i <= 4; i++) begin
         req_valid_i = 1'b1; req_id_i = IDW'(i);
         tick();
      end
      chk("full_ready", req_ready_o, 0);
      req_id_i = 8'h09;
      tick();
      chk("stall_ready", req_ready_o, 0);
      release_owner(8'h0A);
      chk("stall_ready_drain", req_ready_o, 0);
      tick();
      chk("full_pop_ready", req_ready_o, 0);
      wait_gnt(8'h01);
      chk("after_pop_ready", req_ready_o, 1);
      gnt_ready_i = 1'b1;
      tick();
      gnt_ready_i = 1'b0;
      req_valid_i = 1'b0;
      release_owner(8'h01);
      for (int i = 0; i < 4; i++) begin
         wait_gnt(order[i]);
         gnt_ready_i = 1'b1;
         tick();
         gnt_ready_i = 1'b0;
         release_owner(order[i]);
      end
      tick();

      // Reset mid-ownership with three queued requests
      grant_owner(8'h0B);
      for (int i = 0; i < 3; i++) begin
         req_valid_i = 1'b1; req_id_i = IDW'(8'h0C + i);
         tick();
      end
      req_valid_i = 1'b0;
      chk("pre_rst_owner", owner_valid_o, 1);
      #2 arst_ni = 1'b0;
      #1;
      chk("arst_owner_valid", owner_valid_o, 0);
      chk("arst_owner_id",    owner_id_o,    0);
      chk("arst_gnt_valid",   gnt_valid_o,   0);
      chk("arst_req_ready",   req_ready_o,   1);
      chk("arst_timeout",     timeout_o,     0);
      chk("arst_rel_err",     rel_err_o,     0);
      tick();
      tick();
      arst_ni = 1'b1;
      repeat (8) begin
         tick();
         chk("post_rst_no_gnt", gnt_valid_o, 0);
      end
      req_valid_i = 1'b1; req_id_i = 8'h0F;
      tick();
      req_valid_i = 1'b0;
      tick();
      chk("new_req_gnt",    gnt_valid_o, 1);
      chk("new_req_gnt_id", gnt_id_o,    8'h0F);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
      $fatal(1);
   end

endmodule
